// File: rtl/fpu_result_stage_if.sv
// Result channel between the FPU rounder, the result stage and its consumer.
// One instance carries one valid/ready stream of {fp, ieeep, db}.
// master drives valid and the payload; slave drives ready.
interface fpu_result_stage_if #(
    parameter int W     = 64,
    parameter int FLAGW = 5
);
    logic             valid;
    logic             ready;
    logic [W-1:0]     fp;
    logic [FLAGW-1:0] ieeep;
    logic             db;

    modport master (
        output valid,
        output fp,
        output ieeep,
        output db,
        input  ready
    );

    modport slave (
        input  valid,
        input  fp,
        input  ieeep,
        input  db,
        output ready
    );
endinterface

// File: rtl/fpu_result_stage.sv
// Registered result stage behind the combinational FPU (unpack -> add -> round).
// Queues rounded results, their IEEE flags and precision tag in a DEPTH-entry
// FIFO, drains them over valid/ready, and keeps a sticky OR of the flags of
// every accepted result.
// Optional feature macro FPU_TRAP_EN: adds trap_mask/trap/trap_clr. A push whose
// flags hit trap_mask raises trap, which blocks further input until cleared.
module fpu_result_stage #(
    parameter  int DEPTH = 2,
    parameter  int W     = 64,
    parameter  int FLAGW = 5,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fpu_result_stage_if.slave     in_bus,
    fpu_result_stage_if.master    out_bus,
    input  logic                  sticky_clr,
    output logic [FLAGW-1:0]      sticky,
    output logic [CW-1:0]         count
`ifdef FPU_TRAP_EN
    ,
    input  logic [FLAGW-1:0]      trap_mask,
    output logic                  trap,
    input  logic                  trap_clr
`endif
);

    // A single-entry FIFO still needs a 1-bit pointer to index storage.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_fp [DEPTH];
    logic [FLAGW-1:0] mem_fl [DEPTH];
    logic             mem_db [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             not_empty;
    logic             trap_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign not_empty = (count != '0);

    // Readiness depends only on occupancy (and trap), never on a same-cycle pop.
    assign in_bus.ready = (count < CW'(DEPTH)) & ~trap_q;
    assign push         = in_bus.valid & in_bus.ready;
    assign pop          = not_empty & out_bus.ready;

    // Head entry is driven straight from storage; payload reads as zero when empty.
    assign out_bus.valid = not_empty;
    assign out_bus.fp    = not_empty ? mem_fp[rd_ptr] : '0;
    assign out_bus.ieeep = not_empty ? mem_fl[rd_ptr] : '0;
    assign out_bus.db    = not_empty ? mem_db[rd_ptr] : 1'b0;

    // Storage write on push; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_fp[wr_ptr] <= in_bus.fp;
            mem_fl[wr_ptr] <= in_bus.ieeep;
            mem_db[wr_ptr] <= in_bus.db;
        end
    end

    // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Sticky flags are recorded at push; a clear in the same cycle keeps only the new flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky <= '0;
        else
            sticky <= (sticky_clr ? '0 : sticky) | (push ? in_bus.ieeep : '0);
    end

`ifdef FPU_TRAP_EN
    // Trap latches on a masked exception at push; a new hit beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            trap_q <= 1'b0;
        else if (push && ((in_bus.ieeep & trap_mask) != '0))
            trap_q <= 1'b1;
        else if (trap_clr)
            trap_q <= 1'b0;
    end

    assign trap = trap_q;
`else
    assign trap_q = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_result_stage.sv
// Bench for fpu_result_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fpu_result_stage;
    localparam int DEPTH = 2;
    localparam int W     = 64;
    localparam int FLAGW = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             sticky_clr;
    logic [FLAGW-1:0] sticky;
    logic [CW-1:0]    count;
`ifdef FPU_TRAP_EN
    logic [FLAGW-1:0] trap_mask;
    logic             trap;
    logic             trap_clr;
`endif

    fpu_result_stage_if #(.W(W), .FLAGW(FLAGW)) in_if ();
    fpu_result_stage_if #(.W(W), .FLAGW(FLAGW)) out_if ();

    fpu_result_stage #(.DEPTH(DEPTH), .W(W), .FLAGW(FLAGW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_bus     (in_if),
        .out_bus    (out_if),
        .sticky_clr (sticky_clr),
        .sticky     (sticky),
        .count      (count)
`ifdef FPU_TRAP_EN
        ,
        .trap_mask  (trap_mask),
        .trap       (trap),
        .trap_clr   (trap_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queues plus sticky/trap state.
    logic [W-1:0]     fp_q [$];
    logic [FLAGW-1:0] fl_q [$];
    bit               db_q [$];
    logic [FLAGW-1:0] m_sticky = '0;
    bit               m_trap   = 1'b0;

    always @(posedge clk) begin
        bit m_push, m_pop, hit;
        if (!rst_n) begin
            fp_q.delete(); fl_q.delete(); db_q.delete();
            m_sticky = '0;
            m_trap   = 1'b0;
        end else begin
            m_push = in_if.valid && (fp_q.size() < DEPTH) && !m_trap;
            m_pop  = (fp_q.size() != 0) && out_if.ready;
            hit    = 1'b0;
`ifdef FPU_TRAP_EN
            hit = m_push && ((in_if.ieeep & trap_mask) != 0);
`endif
            m_sticky = (sticky_clr ? '0 : m_sticky) | (m_push ? in_if.ieeep : '0);
            if (m_pop) begin
                void'(fp_q.pop_front()); void'(fl_q.pop_front()); void'(db_q.pop_front());
            end
            if (m_push) begin
                fp_q.push_back(in_if.fp); fl_q.push_back(in_if.ieeep); db_q.push_back(in_if.db);
            end
`ifdef FPU_TRAP_EN
            if (hit) m_trap = 1'b1;
            else if (trap_clr) m_trap = 1'b0;
`endif
        end
        #1;
        if (chk_en) begin
            bit ne;
            ne = (fp_q.size() != 0);
            chk("count",     64'(count),        64'(fp_q.size()));
            chk("out_valid", 64'(out_if.valid), 64'(ne));
            chk("in_ready",  64'(in_if.ready),  64'((fp_q.size() < DEPTH) && !m_trap));
            chk("fp_out",    64'(out_if.fp),    ne ? 64'(fp_q[0]) : 64'd0);
            chk("ieeep_out", 64'(out_if.ieeep), ne ? 64'(fl_q[0]) : 64'd0);
            chk("db_out",    64'(out_if.db),    ne ? 64'(db_q[0]) : 64'd0);
            chk("sticky",    64'(sticky),       64'(m_sticky));
`ifdef FPU_TRAP_EN
            chk("trap",      64'(trap),         64'(m_trap));
`endif
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [W-1:0] f, input logic [FLAGW-1:0] fl,
                         input bit d, input bit rdy);
        in_if.valid = v; in_if.fp = f; in_if.ieeep = fl; in_if.db = d; out_if.ready = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        sticky_clr = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
`ifdef FPU_TRAP_EN
        trap_mask = '0;
        trap_clr  = 1'b0;
`endif
        repeat (3) nxt();
        rst_n = 1'b1;
        chk_en = 1'b1;
        nxt();

        // 1: idle after reset
        chk("t1_out_valid", 64'(out_if.valid), 64'd0);
        chk("t1_in_ready",  64'(in_if.ready),  64'd1);
        chk("t1_count",     64'(count),        64'd0);
        chk("t1_sticky",    64'(sticky),       64'd0);
        chk("t1_fp_out",    64'(out_if.fp),    64'd0);

        // 2: single result passes through with one cycle latency
        drive(1'b1, 64'h3FF0_0000_0000_0000, 5'b10000, 1'b1, 1'b1);
        nxt();
        in_if.valid = 1'b0;
        chk("t2_out_valid", 64'(out_if.valid), 64'd1);
        chk("t2_fp_out",    64'(out_if.fp),    64'h3FF0_0000_0000_0000);
        nxt();
        chk("t2_popped",    64'(out_if.valid), 64'd0);
        chk("t2_sticky",    64'(sticky),       64'b10000);

        // 3: fill, ignore third, drain in order
        drive(1'b1, 64'hAAAA_0000_0000_0001, 5'b00001, 1'b0, 1'b0);
        nxt();
        drive(1'b1, 64'hBBBB_0000_0000_0002, 5'b00010, 1'b1, 1'b0);
        nxt();
        drive(1'b1, 64'hCCCC_0000_0000_0003, 5'b00000, 1'b0, 1'b0);
        chk("t3_count_full", 64'(count),       64'd2);
        chk("t3_in_ready",   64'(in_if.ready), 64'd0);
        nxt();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        chk("t3_count_hold", 64'(count),       64'd2);
        chk("t3_head_a",     64'(out_if.fp),   64'hAAAA_0000_0000_0001);
        nxt();
        chk("t3_head_b",     64'(out_if.fp),   64'hBBBB_0000_0000_0002);
        chk("t3_db_b",       64'(out_if.db),   64'd1);
        nxt();
        chk("t3_empty",      64'(out_if.valid), 64'd0);

        // 4: clear + push keeps only new flags
        sticky_clr = 1'b1;
        nxt();
        sticky_clr = 1'b0;
        drive(1'b1, 64'h1, 5'b00100, 1'b0, 1'b1);
        nxt();
        chk("t4_sticky_pre", 64'(sticky), 64'b00100);
        sticky_clr = 1'b1;
        drive(1'b1, 64'h2, 5'b01000, 1'b0, 1'b1);
        nxt();
        chk("t4_sticky_post", 64'(sticky), 64'b01000);
        sticky_clr = 1'b0;

        // 5: push+pop at count=1, then async reset mid-stream
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        nxt();
        chk("t5_count1", 64'(count), 64'd1);
        drive(1'b1, 64'hC0C0_C0C0_C0C0_C0C0, 5'b00000, 1'b1, 1'b1);
        nxt();
        chk("t5_count_same", 64'(count),     64'd1);
        chk("t5_head_c",     64'(out_if.fp), 64'hC0C0_C0C0_C0C0_C0C0);
        drive(1'b1, 64'hE, 5'b00001, 1'b0, 1'b0);
        nxt();
        in_if.valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_count", 64'(count),        64'd0);
        chk("t5_rst_valid", 64'(out_if.valid), 64'd0);
        chk("t5_rst_fp",    64'(out_if.fp),    64'd0);
        nxt();
        rst_n = 1'b1;
        nxt();

`ifdef FPU_TRAP_EN
        // 6: trap blocks input, entry still drains, clear restores
        trap_mask = 5'b00100;
        drive(1'b1, 64'h7FF0_0000_0000_0000, 5'b00100, 1'b1, 1'b0);
        nxt();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        chk("t6_trap",      64'(trap),         64'd1);
        chk("t6_in_ready",  64'(in_if.ready),  64'd0);
        chk("t6_out_valid", 64'(out_if.valid), 64'd1);
        nxt();
        chk("t6_drained",   64'(out_if.valid), 64'd0);
        chk("t6_trap_hold", 64'(trap),         64'd1);
        trap_clr = 1'b1;
        nxt();
        trap_clr = 1'b0;
        chk("t6_trap_clr",  64'(trap),         64'd0);
        chk("t6_ready_back", 64'(in_if.ready), 64'd1);
`endif

        // Randomized traffic checked by the per-cycle model compare
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 2) != 0), {$urandom, $urandom},
                  5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom_range(0, 2) != 0));
            sticky_clr = ($urandom_range(0, 7) == 0);
`ifdef FPU_TRAP_EN
            if ($urandom_range(0, 15) == 0) trap_mask = 5'($urandom_range(0, 31) & 5'b00111);
            trap_clr = ($urandom_range(0, 3) == 0);
`endif
            if (i == 300) begin
                rst_n = 1'b0;
                nxt();
                rst_n = 1'b1;
            end
            nxt();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        sticky_clr = 1'b0;
        repeat (4) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
